// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared constants for the JSP APB core: register map, IIR codes, LSR bits.
// Optional feature macro: PERIPHERAL_DBG_JSP_RX_TRIGGER_EN (see top).
package peripheral_dbg_pu_riscv_pkg;
    localparam logic [2:0] ADDR_RBR = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_IIR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_MCR = 3'd4;
    localparam logic [2:0] ADDR_LSR = 3'd5;
    localparam logic [2:0] ADDR_MSR = 3'd6;
    localparam logic [2:0] ADDR_SCR = 3'd7;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_RLS  = 8'h06;
    localparam logic [7:0] MSR_VAL  = 8'h0B;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;
endpackage

// File: rtl/peripheral_dbg_pu_riscv_jsp_fifo.sv
// Byte FIFO with synchronous clear and show-ahead head output.
// Push/pop are ignored when full/empty; clear beats both.
module peripheral_dbg_pu_riscv_jsp_fifo #(
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [7:0]       data_i,
    input  logic             pop_i,
    output logic [7:0]       data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_o = cnt_q;
    assign data_o  = empty_o ? 8'h00 : mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/peripheral_dbg_pu_riscv_jsp_apb_fifo.sv
// JSP APB core: 16550-style registers over RX/TX byte FIFOs.
// Macro PERIPHERAL_DBG_JSP_RX_TRIGGER_EN enables FCR[7:6] RX trigger select.
module peripheral_dbg_pu_riscv_jsp_apb_fifo
    import peripheral_dbg_pu_riscv_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [2:0]       PADDR,
    input  logic [7:0]       PWDATA,
    output logic [7:0]       PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [7:0]       dbg_wr_data_i,
    input  logic             dbg_wr_valid_i,
    output logic             dbg_wr_ready_o,
    output logic [7:0]       dbg_rd_data_o,
    output logic             dbg_rd_valid_o,
    input  logic             dbg_rd_ready_i,
    output logic [CNT_W-1:0] dbg_rx_free_o,
    output logic [CNT_W-1:0] dbg_tx_avail_o,
    output logic             int_o
);
    logic [3:0]       ier_q;
    logic [7:0]       lcr_q, scr_q, dll_q, dlm_q;
    logic             oe_q, arm_q, oe_d, arm_d;
    logic [7:0]       rx_head, iir, lsr;
    logic [CNT_W-1:0] rx_cnt, tx_cnt, trig;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             acc, rd, wr, dlab;
    logic             rbr_rd, thr_wr, fcr_wr, ier_wr, lsr_rd, iir_rd;
    logic             rx_push, rx_pop, tx_push, tx_pop;

    assign acc    = PSEL & PENABLE;
    assign rd     = acc & ~PWRITE;
    assign wr     = acc & PWRITE;
    assign dlab   = lcr_q[7];
    assign rbr_rd = rd & (PADDR == ADDR_RBR) & ~dlab;
    assign thr_wr = wr & (PADDR == ADDR_RBR) & ~dlab;
    assign ier_wr = wr & (PADDR == ADDR_IER) & ~dlab;
    assign fcr_wr = wr & (PADDR == ADDR_IIR);
    assign iir_rd = rd & (PADDR == ADDR_IIR);
    assign lsr_rd = rd & (PADDR == ADDR_LSR);

    assign rx_push = dbg_wr_valid_i & ~rx_full;
    assign rx_pop  = rbr_rd & ~rx_empty;
    assign tx_push = thr_wr & ~tx_full;
    assign tx_pop  = dbg_rd_ready_i & ~tx_empty;

    peripheral_dbg_pu_riscv_jsp_fifo #(.DEPTH(DEPTH)) u_rx (
        .clk_i(PCLK), .rst_ni(PRESETn),
        .clr_i(fcr_wr & PWDATA[1]),
        .push_i(rx_push), .data_i(dbg_wr_data_i),
        .pop_i(rx_pop), .data_o(rx_head),
        .count_o(rx_cnt), .full_o(rx_full), .empty_o(rx_empty)
    );

    peripheral_dbg_pu_riscv_jsp_fifo #(.DEPTH(DEPTH)) u_tx (
        .clk_i(PCLK), .rst_ni(PRESETn),
        .clr_i(fcr_wr & PWDATA[2]),
        .push_i(tx_push), .data_i(PWDATA),
        .pop_i(tx_pop), .data_o(dbg_rd_data_o),
        .count_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty)
    );

`ifdef PERIPHERAL_DBG_JSP_RX_TRIGGER_EN
    logic [1:0] trig_q;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)    trig_q <= 2'b00;
        else if (fcr_wr) trig_q <= PWDATA[7:6];
    end
    always_comb begin
        unique case (trig_q)
            2'b00:   trig = CNT_W'(1);
            2'b01:   trig = CNT_W'(DEPTH / 4);
            2'b10:   trig = CNT_W'(DEPTH / 2);
            default: trig = CNT_W'(DEPTH - 2);
        endcase
    end
`else
    assign trig = CNT_W'(1);
`endif

    always_comb begin
        if (oe_q && ier_q[2])                iir = IIR_RLS;
        else if (rx_cnt >= trig && ier_q[0]) iir = IIR_RDA;
        else if (arm_q && tx_empty && ier_q[1]) iir = IIR_THRE;
        else                                 iir = IIR_NONE;
    end

    assign lsr = {1'b0, tx_empty, ~tx_full, 3'b000, oe_q, ~rx_empty};

    always_comb begin
        unique case (PADDR)
            ADDR_RBR: PRDATA = dlab ? dll_q : rx_head;
            ADDR_IER: PRDATA = dlab ? dlm_q : {4'h0, ier_q};
            ADDR_IIR: PRDATA = iir;
            ADDR_LCR: PRDATA = lcr_q;
            ADDR_MCR: PRDATA = 8'h00;
            ADDR_LSR: PRDATA = lsr;
            ADDR_MSR: PRDATA = MSR_VAL;
            default:  PRDATA = scr_q;
        endcase
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = (rbr_rd & rx_empty) | (thr_wr & tx_full);

    // A set always beats a same-cycle clear for both sticky flags.
    assign oe_d  = (thr_wr & tx_full) | (oe_q & ~lsr_rd);
    assign arm_d = (tx_pop & (tx_cnt == CNT_W'(1)) & ~tx_push)
                 | (ier_wr & PWDATA[1] & ~ier_q[1])
                 | (arm_q & ~(thr_wr | (iir_rd & (iir == IIR_THRE))));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ier_q <= '0;
            lcr_q <= '0;
            scr_q <= '0;
            dll_q <= '0;
            dlm_q <= '0;
            oe_q  <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            oe_q  <= oe_d;
            arm_q <= arm_d;
            if (ier_wr) ier_q <= PWDATA[3:0];
            if (wr && PADDR == ADDR_RBR && dlab) dll_q <= PWDATA;
            if (wr && PADDR == ADDR_IER && dlab) dlm_q <= PWDATA;
            if (wr && PADDR == ADDR_LCR) lcr_q <= PWDATA;
            if (wr && PADDR == ADDR_SCR) scr_q <= PWDATA;
        end
    end

    assign dbg_wr_ready_o = ~rx_full;
    assign dbg_rd_valid_o = ~tx_empty;
    assign dbg_rx_free_o  = CNT_W'(DEPTH) - rx_cnt;
    assign dbg_tx_avail_o = tx_cnt;
    assign int_o          = (iir != IIR_NONE);
endmodule

// File: doc/peripheral_dbg_pu_riscv_jsp_apb_fifo.md
# peripheral_dbg_pu_riscv_jsp_apb_fifo

Parametrised, single-clock JTAG-serial-port (JSP) APB core: a 16550-style register file in front of two configurable-depth byte FIFOs, with zero-wait-state APB access, overflow/underflow error reporting and a prioritised interrupt identifier. It sits in the PCLK domain between the APB fabric and the debug unit's JSP channel. The debug side connects through valid/ready byte streams that are already synchronised to PCLK; clock-domain crossing stays outside this block.

## Interface
- DEPTH, 16, entries per FIFO; power of two, at least 4.
- CNT_W, $clog2(DEPTH)+1, derived localparam, not overridable; width of all occupancy counts.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  3  register address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data; combinational.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  access error; valid in the access phase.
- dbg_wr_data_i  in  8  host-to-target byte, pushed into the RX FIFO.
- dbg_wr_valid_i  in  1  byte offered.
- dbg_wr_ready_o  out  1  RX FIFO not full.
- dbg_rd_data_o  out  8  TX FIFO head; show-ahead.
- dbg_rd_valid_o  out  1  TX FIFO not empty.
- dbg_rd_ready_i  in  1  pops the TX FIFO when dbg_rd_valid_o is high.
- dbg_rx_free_o  out  CNT_W  free RX entries.
- dbg_tx_avail_o  out  CNT_W  occupied TX entries.
- int_o  out  1  interrupt, active-high.

## Operation
- **APB access**
  - All accesses complete in the access phase (PSEL & PENABLE); no wait states.
  - Register side effects occur at that clock edge.
- **Register map** (LCR[7]=0):
  - 0: read RBR (pop RX) / write THR (push TX).
  - 1: IER[3:0].
  - 2: read IIR / write FCR.
  - 3: LCR.
  - 4: MCR, reads 0x00.
  - 5: LSR, read-only.
  - 6: MSR, reads 0x0B.
  - 7: SCR.
- **Divisor latch** (LCR[7]=1): addresses 0 and 1 access the DLL/DLM 8-bit storage registers. They reset to 0x00, have no functional effect, and leave the FIFOs untouched.
- **RBR read**
  - RX empty: PRDATA=0x00, PSLVERR=1, no pop.
  - Otherwise: PRDATA is the RX head, which is popped.
- **THR write**
  - TX full: byte dropped, PSLVERR=1, LSR.OE set.
  - Otherwise: byte pushed.
  - Full and empty are judged on the registered counts at the start of the cycle; a same-cycle debug pop does not rescue a write to a full FIFO.
- **FCR write**
  - Bit 1: RX FIFO cleared.
  - Bit 2: TX FIFO cleared.
  - A clear wins over a same-cycle push or pop on that FIFO.
- **LSR bits**
  - [0] DR: RX not empty.
  - [1] OE: sticky; cleared by an LSR read. A set and a clear in the same cycle leave it set.
  - [5]: TX not full.
  - [6]: TX empty.
  - All other bits 0.
- **THR arm**
  - Set when: a debug pop empties TX, or a write raises IER[1].
  - Cleared when: a THR write occurs, or an IIR read returns 0x02.
- **IIR priority** (highest first):
  - 0x06: OE & IER[2].
  - 0x04: RX count ≥ trigger level & IER[0].
  - 0x02: arm & TX empty & IER[1].
  - 0x01: otherwise.
- **int_o**: high when IIR≠0x01.
- **Simultaneous push and pop** on one FIFO in one cycle: both take effect and the count is unchanged. A push into a full FIFO cannot occur, because ready/valid gate it.

## Timing
- **Reset values**:
  - PRDATA follows PADDR.
  - PREADY=1, PSLVERR=0.
  - dbg_wr_ready_o=1, dbg_rd_valid_o=0, dbg_rd_data_o=0x00.
  - dbg_rx_free_o=DEPTH, dbg_tx_avail_o=0.
  - int_o=0.
  - Registers read: IER 0, LCR 0, SCR 0, LSR 0x60, IIR 0x01.
- **THR write** at edge N: dbg_rd_valid_o and dbg_rd_data_o are valid after edge N.
- **Debug push** at edge N: LSR.DR, counts and int_o reflect it after edge N.
- **RBR read**: returns data in the same access cycle; the pop is committed at that edge.
- **int_o** is combinational from registered state; it has no path from APB inputs.
- **Reset mid-transfer**: both FIFOs empty, all state returns to reset values immediately; a byte being pushed is lost.

## Configuration
- **PERIPHERAL_DBG_JSP_RX_TRIGGER_EN defined**: FCR[7:6] is stored (reset 00) and selects the RX trigger level:
  - 00: 1
  - 01: DEPTH/4
  - 10: DEPTH/2
  - 11: DEPTH-2
- **Not defined**: FCR[7:6] is ignored and the trigger level is fixed at 1.

## Structure
- **Package peripheral_dbg_pu_riscv_pkg**:
  - register address constants;
  - IIR code constants;
  - LSR bit indices.
- **Sub-module peripheral_dbg_pu_riscv_jsp_fifo**, instantiated twice:
  - parameter DEPTH;
  - synchronous clear;
  - show-ahead head output;
  - CNT_W-bit count, plus full and empty flags.

## Test plan
- **Reset**: reset, then read LSR/IIR/IER → 0x60 / 0x01 / 0x00; int_o=0; dbg_rx_free_o=16.
- **RX path and interrupt**: IER=0x01; debug pushes 0x41 and 0x42 → IIR=0x04, int_o=1. RBR reads return 0x41 then 0x42 → IIR=0x01. A third RBR read returns 0x00 with PSLVERR=1.
- **TX overflow**: THR writes 0..16 with dbg_rd_ready_i=0 → the 17th write gets PSLVERR=1 and LSR=0x02 (OE set; TX not full 0; TX empty 0). Drain → bytes 0..15 in order. Read LSR → OE clears.
- **THR-empty interrupt**: IER=0x02, write THR 0x55, debug pops it → IIR=0x02, int_o=1. Read IIR → next IIR read 0x01.
- **Simultaneous events and FIFO clear**: debug push and RBR read in the same cycle with RX count 3 → count stays 3. Write FCR=0x06 → both FIFOs empty and dbg_rx_free_o=16.
- **Trigger level** (macro defined): FCR=0xC0 with IER=0x01 → IIR=0x04 appears only at RX count 14. Macro undefined: IIR=0x04 appears at count 1.
